// File: rtl/vga_crtc_timing.sv
// vga_crtc_timing: character-clocked CRT controller timing generator.
// Produces counters, syncs, blanking and display enable from shadowed CRTC regs.
module vga_crtc_timing #(
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       char_en_i,
  input  logic [7:0] crtc_horiz_total_i,
  input  logic [7:0] crtc_horiz_disp_en_cnt_i,
  input  logic [7:0] crtc_horiz_blank_start_i,
  input  logic [5:0] crtc_horiz_blank_end_i,
  input  logic [7:0] crtc_horiz_retrace_start_i,
  input  logic [4:0] crtc_horiz_retrace_end_i,
  input  logic [9:0] crtc_vert_total_i,
  input  logic [9:0] crtc_vert_disp_en_end_i,
  input  logic [9:0] crtc_vert_blank_start_i,
  input  logic [7:0] crtc_vert_blank_end_i,
  input  logic [9:0] crtc_vert_retrace_start_i,
  input  logic [3:0] crtc_vert_retrace_end_i,
  output logic [7:0] hcount_o,
  output logic [9:0] vcount_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       blank_o,
  output logic       de_o,
  output logic       line_start_o,
  output logic       frame_start_o
);

  typedef struct packed {
    logic [7:0] h_total;
    logic [7:0] h_disp;
    logic [7:0] h_bstart;
    logic [5:0] h_bend;
    logic [7:0] h_rstart;
    logic [4:0] h_rend;
    logic [9:0] v_total;
    logic [9:0] v_disp;
    logic [9:0] v_bstart;
    logic [7:0] v_bend;
    logic [9:0] v_rstart;
    logic [3:0] v_rend;
  } crtc_regs_t;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t     state_q;
  state_t     state_d;
  crtc_regs_t regs_in;
  crtc_regs_t shadow_q;
  crtc_regs_t shadow_d;

  logic       start;
  logic       h_at_end;
  logic       v_at_end;
  logic       h_wrap;
  logic       f_wrap;
  logic       load;
  logic [7:0] h_next;
  logic [9:0] v_next;

  logic       hblank_q;
  logic       hretrace_q;
  logic       vblank_q;
  logic       vretrace_q;
  logic       hblank_d;
  logic       hretrace_d;
  logic       vblank_d;
  logic       vretrace_d;
  logic       h_de;
  logic       v_de;

  assign regs_in = '{
    h_total:  crtc_horiz_total_i,
    h_disp:   crtc_horiz_disp_en_cnt_i,
    h_bstart: crtc_horiz_blank_start_i,
    h_bend:   crtc_horiz_blank_end_i,
    h_rstart: crtc_horiz_retrace_start_i,
    h_rend:   crtc_horiz_retrace_end_i,
    v_total:  crtc_vert_total_i,
    v_disp:   crtc_vert_disp_en_end_i,
    v_bstart: crtc_vert_blank_start_i,
    v_bend:   crtc_vert_blank_end_i,
    v_rstart: crtc_vert_retrace_start_i,
    v_rend:   crtc_vert_retrace_end_i
  };

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_INIT;
    end else if (char_en_i) begin
      state_q <= state_d;
    end
  end

  // The first enabled cycle after reset lands on (0,0) and loads shadows.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        start   = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // Terminal count also at all-ones so a shrunk total cannot lock up.
  always_comb begin
    h_at_end = (hcount_o == shadow_q.h_total) || (&hcount_o);
    v_at_end = (vcount_o == shadow_q.v_total) || (&vcount_o);
    h_wrap   = start | h_at_end;
    f_wrap   = start | (h_at_end & v_at_end);
    load     = char_en_i & f_wrap;
    shadow_d = load ? regs_in : shadow_q;
  end

  always_comb begin
    h_next = hcount_o + 8'd1;
    v_next = vcount_o;
    if (f_wrap) begin
      h_next = '0;
      v_next = '0;
    end else if (h_wrap) begin
      h_next = '0;
      v_next = vcount_o + 10'd1;
    end
  end

  // Flags: set first, clear afterwards so clear wins on a tie.
  always_comb begin
    hblank_d   = hblank_q;
    hretrace_d = hretrace_q;
    vblank_d   = vblank_q;
    vretrace_d = vretrace_q;
    if (h_next == shadow_d.h_bstart)
      hblank_d = 1'b1;
    if (h_next[5:0] == shadow_d.h_bend)
      hblank_d = 1'b0;
    if (h_next == shadow_d.h_rstart)
      hretrace_d = 1'b1;
    if (h_next[4:0] == shadow_d.h_rend)
      hretrace_d = 1'b0;
    if (h_wrap) begin
      if (v_next == shadow_d.v_bstart)
        vblank_d = 1'b1;
      if (v_next[7:0] == shadow_d.v_bend)
        vblank_d = 1'b0;
      if (v_next == shadow_d.v_rstart)
        vretrace_d = 1'b1;
      if (v_next[3:0] == shadow_d.v_rend)
        vretrace_d = 1'b0;
    end
    h_de = (h_next <= shadow_d.h_disp);
    v_de = (v_next <= shadow_d.v_disp);
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      shadow_q      <= '0;
      hcount_o      <= '0;
      vcount_o      <= '0;
      hblank_q      <= 1'b0;
      hretrace_q    <= 1'b0;
      vblank_q      <= 1'b0;
      vretrace_q    <= 1'b0;
      hsync_o       <= ~HSYNC_POL;
      vsync_o       <= ~VSYNC_POL;
      blank_o       <= 1'b1;
      de_o          <= 1'b0;
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
    end else begin
      shadow_q      <= shadow_d;
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
      if (char_en_i) begin
        hcount_o      <= h_next;
        vcount_o      <= v_next;
        hblank_q      <= hblank_d;
        hretrace_q    <= hretrace_d;
        vblank_q      <= vblank_d;
        vretrace_q    <= vretrace_d;
        hsync_o       <= hretrace_d ? HSYNC_POL : ~HSYNC_POL;
        vsync_o       <= vretrace_d ? VSYNC_POL : ~VSYNC_POL;
        blank_o       <= hblank_d | vblank_d;
        de_o          <= h_de & v_de;
        line_start_o  <= h_wrap;
        frame_start_o <= f_wrap;
      end
    end
  end

endmodule

// File: tb/tb_vga_crtc_timing.sv
// tb_vga_crtc_timing: scoreboard bench for vga_crtc_timing.
// A behavioural model queues expected outputs per clock; tests pop and compare.
module tb_vga_crtc_timing;

  typedef struct packed {
    logic [7:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       bl;
    logic       de;
    logic       ls;
    logic       fs;
  } out_t;

  localparam out_t RESET_OUT = '{h: 8'd0, v: 10'd0, hs: 1'b1, vs: 1'b1,
                                 bl: 1'b1, de: 1'b0, ls: 1'b0, fs: 1'b0};

  logic       clock_i = 1'b0;
  logic       reset_i;
  logic       char_en_i;
  logic [7:0] crtc_horiz_total_i;
  logic [7:0] crtc_horiz_disp_en_cnt_i;
  logic [7:0] crtc_horiz_blank_start_i;
  logic [5:0] crtc_horiz_blank_end_i;
  logic [7:0] crtc_horiz_retrace_start_i;
  logic [4:0] crtc_horiz_retrace_end_i;
  logic [9:0] crtc_vert_total_i;
  logic [9:0] crtc_vert_disp_en_end_i;
  logic [9:0] crtc_vert_blank_start_i;
  logic [7:0] crtc_vert_blank_end_i;
  logic [9:0] crtc_vert_retrace_start_i;
  logic [3:0] crtc_vert_retrace_end_i;
  logic [7:0] hcount_o;
  logic [9:0] vcount_o;
  logic       hsync_o;
  logic       vsync_o;
  logic       blank_o;
  logic       de_o;
  logic       line_start_o;
  logic       frame_start_o;

  out_t obs;
  out_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  // Model state
  bit   m_started;
  int   m_h, m_v;
  bit   m_hb, m_hr, m_vb, m_vr;
  int   sh_ht, sh_hd, sh_hbs, sh_hbe, sh_hrs, sh_hre;
  int   sh_vt, sh_vd, sh_vbs, sh_vbe, sh_vrs, sh_vre;
  out_t m_out;

  assign obs = {hcount_o, vcount_o, hsync_o, vsync_o,
                blank_o, de_o, line_start_o, frame_start_o};

  always #5 clock_i = ~clock_i;

  vga_crtc_timing dut (
    .clock_i                    (clock_i),
    .reset_i                    (reset_i),
    .char_en_i                  (char_en_i),
    .crtc_horiz_total_i         (crtc_horiz_total_i),
    .crtc_horiz_disp_en_cnt_i   (crtc_horiz_disp_en_cnt_i),
    .crtc_horiz_blank_start_i   (crtc_horiz_blank_start_i),
    .crtc_horiz_blank_end_i     (crtc_horiz_blank_end_i),
    .crtc_horiz_retrace_start_i (crtc_horiz_retrace_start_i),
    .crtc_horiz_retrace_end_i   (crtc_horiz_retrace_end_i),
    .crtc_vert_total_i          (crtc_vert_total_i),
    .crtc_vert_disp_en_end_i    (crtc_vert_disp_en_end_i),
    .crtc_vert_blank_start_i    (crtc_vert_blank_start_i),
    .crtc_vert_blank_end_i      (crtc_vert_blank_end_i),
    .crtc_vert_retrace_start_i  (crtc_vert_retrace_start_i),
    .crtc_vert_retrace_end_i    (crtc_vert_retrace_end_i),
    .hcount_o                   (hcount_o),
    .vcount_o                   (vcount_o),
    .hsync_o                    (hsync_o),
    .vsync_o                    (vsync_o),
    .blank_o                    (blank_o),
    .de_o                       (de_o),
    .line_start_o               (line_start_o),
    .frame_start_o              (frame_start_o)
  );

  task automatic model_reset();
    m_started = 0;
    m_h = 0; m_v = 0;
    m_hb = 0; m_hr = 0; m_vb = 0; m_vr = 0;
    sh_ht = 0; sh_hd = 0; sh_hbs = 0; sh_hbe = 0; sh_hrs = 0; sh_hre = 0;
    sh_vt = 0; sh_vd = 0; sh_vbs = 0; sh_vbe = 0; sh_vrs = 0; sh_vre = 0;
    m_out = RESET_OUT;
    exp_q.delete();
  endtask

  task automatic model_step(input logic en);
    out_t e;
    bit   nl, nf;
    nl = 0;
    nf = 0;
    if (en) begin
      if (!m_started) begin
        m_started = 1; m_h = 0; m_v = 0; nl = 1; nf = 1;
      end else if (m_h == sh_ht || m_h == 255) begin
        m_h = 0; nl = 1;
        if (m_v == sh_vt || m_v == 1023) begin
          m_v = 0; nf = 1;
        end else begin
          m_v = m_v + 1;
        end
      end else begin
        m_h = m_h + 1;
      end
      if (nf) begin
        sh_ht  = int'(crtc_horiz_total_i);
        sh_hd  = int'(crtc_horiz_disp_en_cnt_i);
        sh_hbs = int'(crtc_horiz_blank_start_i);
        sh_hbe = int'(crtc_horiz_blank_end_i);
        sh_hrs = int'(crtc_horiz_retrace_start_i);
        sh_hre = int'(crtc_horiz_retrace_end_i);
        sh_vt  = int'(crtc_vert_total_i);
        sh_vd  = int'(crtc_vert_disp_en_end_i);
        sh_vbs = int'(crtc_vert_blank_start_i);
        sh_vbe = int'(crtc_vert_blank_end_i);
        sh_vrs = int'(crtc_vert_retrace_start_i);
        sh_vre = int'(crtc_vert_retrace_end_i);
      end
      if (m_h == sh_hbs) m_hb = 1;
      if ((m_h % 64) == sh_hbe) m_hb = 0;
      if (m_h == sh_hrs) m_hr = 1;
      if ((m_h % 32) == sh_hre) m_hr = 0;
      if (nl) begin
        if (m_v == sh_vbs) m_vb = 1;
        if ((m_v % 256) == sh_vbe) m_vb = 0;
        if (m_v == sh_vrs) m_vr = 1;
        if ((m_v % 16) == sh_vre) m_vr = 0;
      end
      m_out.h  = 8'(m_h);
      m_out.v  = 10'(m_v);
      m_out.hs = !m_hr;
      m_out.vs = !m_vr;
      m_out.bl = m_hb || m_vb;
      m_out.de = (m_h <= sh_hd) && (m_v <= sh_vd);
    end
    e = m_out;
    e.ls = nl;
    e.fs = nf;
    exp_q.push_back(e);
  endtask

  task automatic tick(input logic en);
    char_en_i = en;
    model_step(en);
    @(posedge clock_i);
    #1;
  endtask

  task automatic set_basic();
    crtc_horiz_total_i         = 8'd9;
    crtc_horiz_disp_en_cnt_i   = 8'd5;
    crtc_horiz_blank_start_i   = 8'd6;
    crtc_horiz_blank_end_i     = 6'd9;
    crtc_horiz_retrace_start_i = 8'd7;
    crtc_horiz_retrace_end_i   = 5'd8;
    crtc_vert_total_i          = 10'd4;
    crtc_vert_disp_en_end_i    = 10'd2;
    crtc_vert_blank_start_i    = 10'd3;
    crtc_vert_blank_end_i      = 8'd4;
    crtc_vert_retrace_start_i  = 10'd3;
    crtc_vert_retrace_end_i    = 4'd4;
  endtask

  task automatic do_reset();
    reset_i   = 1'b1;
    char_en_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clock_i);
    #1;
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    out_t e;
    reset_i   = 1'b1;
    char_en_i = 1'b1;
    model_reset();
    repeat (3) @(posedge clock_i);
    #1;
    checks++;
    if (obs !== RESET_OUT)
      $display("FAIL reset_held: got %h want %h", obs, RESET_OUT);
    else
      passed++;
    reset_i = 1'b0;
    tick(1'b0);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e)
      $display("FAIL reset_idle: got %h want %h", obs, e);
    else
      passed++;
  endtask

  task automatic test_basic_line();
    out_t e, d;
    do_reset();
    set_basic();
    for (int k = 0; k < 11; k++) begin
      tick(1'b1);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e)
        $display("FAIL basic_sb k=%0d: got %h want %h", k, obs, e);
      else
        passed++;
      d = '{h: 8'(k % 10), v: 10'(k / 10), hs: (k != 7), vs: 1'b1,
            bl: (k >= 6 && k <= 8), de: (k <= 5 || k == 10),
            ls: (k == 0 || k == 10), fs: (k == 0)};
      checks++;
      if (obs !== d)
        $display("FAIL basic_line k=%0d: got %h want %h", k, obs, d);
      else
        passed++;
    end
  endtask

  task automatic test_frame();
    out_t e;
    int   fs_at[$];
    int   bad;
    int   h, v;
    do_reset();
    set_basic();
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      tick(1'b1);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e)
        $display("FAIL frame_sb k=%0d: got %h want %h", k, obs, e);
      else
        passed++;
      h = k % 10;
      v = (k / 10) % 5;
      if (obs.fs) fs_at.push_back(k);
      if (obs.vs !== (v != 3)) bad++;
      if (v == 3 && obs.bl !== 1'b1) bad++;
      if (obs.de !== (v <= 2 && h <= 5)) bad++;
    end
    checks++;
    if (bad != 0)
      $display("FAIL frame_shape: got %0d bad cycles want 0", bad);
    else
      passed++;
    checks++;
    if (fs_at.size() != 2)
      $display("FAIL frame_count: got %0d want 2", fs_at.size());
    else if (fs_at[1] - fs_at[0] != 50)
      $display("FAIL frame_period: got %0d want 50", fs_at[1] - fs_at[0]);
    else
      passed++;
  endtask

  task automatic test_enable_gating();
    out_t e;
    int   j, ls_cnt, bad;
    do_reset();
    set_basic();
    j = 0; ls_cnt = 0; bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick((i % 2) == 0);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e)
        $display("FAIL gate_sb i=%0d: got %h want %h", i, obs, e);
      else
        passed++;
      if ((i % 2) == 1) begin
        if (obs.ls !== 1'b0 || obs.fs !== 1'b0) bad++;
      end else begin
        if (obs.h !== 8'(j % 10)) bad++;
        if (obs.ls) ls_cnt++;
        j++;
      end
    end
    checks++;
    if (bad != 0 || ls_cnt != 2)
      $display("FAIL gate_rate: got bad=%0d ls=%0d want 0 2", bad, ls_cnt);
    else
      passed++;
  endtask

  task automatic test_shadow();
    out_t e;
    int   ls_at[$];
    do_reset();
    set_basic();
    for (int c = 0; c < 70; c++) begin
      if (c == 15) crtc_horiz_total_i = 8'd7;
      tick(1'b1);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e)
        $display("FAIL shadow_sb c=%0d: got %h want %h", c, obs, e);
      else
        passed++;
      if (obs.ls) ls_at.push_back(c);
    end
    checks++;
    if (ls_at.size() != 8)
      $display("FAIL shadow_lines: got %0d want 8", ls_at.size());
    else if (ls_at[5] - ls_at[4] != 10 || ls_at[5] != 50 ||
             ls_at[6] - ls_at[5] != 8 || ls_at[7] - ls_at[6] != 8)
      $display("FAIL shadow_period: got %0d %0d %0d want 10 8 8",
               ls_at[5] - ls_at[4], ls_at[6] - ls_at[5], ls_at[7] - ls_at[6]);
    else
      passed++;
  endtask

  task automatic test_reset_mid_frame();
    out_t e, first;
    do_reset();
    set_basic();
    for (int k = 0; k < 25; k++) begin
      tick(1'b1);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e)
        $display("FAIL midrst_pre k=%0d: got %h want %h", k, obs, e);
      else
        passed++;
    end
    checks++;
    if (obs.h !== 8'd4 || obs.v !== 10'd2)
      $display("FAIL midrst_pos: got %0d,%0d want 4,2", obs.h, obs.v);
    else
      passed++;
    #2;
    reset_i = 1'b1;
    #1;
    checks++;
    if (obs !== RESET_OUT)
      $display("FAIL midrst_async: got %h want %h", obs, RESET_OUT);
    else
      passed++;
    model_reset();
    @(posedge clock_i);
    #1;
    reset_i = 1'b0;
    first = '{h: 8'd0, v: 10'd0, hs: 1'b1, vs: 1'b1,
              bl: 1'b0, de: 1'b1, ls: 1'b1, fs: 1'b1};
    for (int k = 0; k < 12; k++) begin
      tick(1'b1);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e)
        $display("FAIL midrst_post k=%0d: got %h want %h", k, obs, e);
      else
        passed++;
      if (k == 0) begin
        checks++;
        if (obs !== first)
          $display("FAIL midrst_restart: got %h want %h", obs, first);
        else
          passed++;
      end
    end
  endtask

  task automatic test_wraparound();
    out_t e;
    int   bad;
    do_reset();
    set_basic();
    crtc_horiz_total_i         = 8'd40;
    crtc_horiz_disp_en_cnt_i   = 8'd25;
    crtc_horiz_blank_start_i   = 8'd35;
    crtc_horiz_blank_end_i     = 6'd38;
    crtc_horiz_retrace_start_i = 8'd30;
    crtc_horiz_retrace_end_i   = 5'd2;
    bad = 0;
    for (int k = 0; k < 41; k++) begin
      tick(1'b1);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e)
        $display("FAIL wrap_sb k=%0d: got %h want %h", k, obs, e);
      else
        passed++;
      if (obs.h !== 8'(k)) bad++;
      if (obs.hs !== !(k >= 30 && k <= 33)) bad++;
    end
    checks++;
    if (bad != 0)
      $display("FAIL wrap_hsync: got %0d bad cycles want 0", bad);
    else
      passed++;
  endtask

  initial begin
    reset_i   = 1'b1;
    char_en_i = 1'b0;
    set_basic();
    model_reset();
    test_reset();
    test_basic_line();
    test_frame();
    test_enable_gating();
    test_shadow();
    test_reset_mid_frame();
    test_wraparound();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/vga_crtc_timing.md
VGA_CRTC_TIMING -- requirements
Module: vga_crtc_timing

Interface
REQ-001 SHALL have parameter HSYNC_POL, default 0, meaning the hsync_o level during horizontal retrace (0 = active-low).
REQ-002 SHALL have parameter VSYNC_POL, default 0, meaning the vsync_o level during vertical retrace.
REQ-003 SHALL have port clock_i, input, 1 bit: the single clock; all logic on the rising edge.
REQ-004 SHALL have port reset_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port char_en_i, input, 1 bit: character-clock enable; counters advance only on cycles where it is high.
REQ-006 SHALL have ports crtc_horiz_total_i, crtc_horiz_disp_en_cnt_i, crtc_horiz_blank_start_i, crtc_horiz_retrace_start_i, inputs, 8 bits each: horizontal register values in characters.
REQ-007 SHALL have ports crtc_horiz_blank_end_i (6 bits) and crtc_horiz_retrace_end_i (5 bits), inputs.
REQ-008 SHALL have ports crtc_vert_total_i, crtc_vert_disp_en_end_i, crtc_vert_blank_start_i, crtc_vert_retrace_start_i, inputs, 10 bits each, in lines.
REQ-009 SHALL have ports crtc_vert_blank_end_i (8 bits) and crtc_vert_retrace_end_i (4 bits), inputs.
REQ-010 SHALL have outputs hcount_o (8 bits) and vcount_o (10 bits): current character and line counters.
REQ-011 SHALL have outputs hsync_o, vsync_o, blank_o and de_o, 1 bit each: syncs, blanking and display enable.
REQ-012 SHALL have outputs line_start_o and frame_start_o, 1 bit each: one-cycle strobes.

Function
REQ-013 SHALL copy all crtc_* inputs into shadow registers only on a char_en_i cycle that is a frame wrap (REQ-015) or the first char_en_i cycle after reset; the timing logic uses shadow values only.
REQ-014 SHALL increment hcount on char_en_i; when hcount equals the shadow horiz_total it SHALL wrap to 0 (line period = total+1 characters).
REQ-015 SHALL, on an hcount wrap, increment vcount; when vcount equals the shadow vert_total it SHALL also wrap to 0 (the frame wrap).
REQ-016 SHALL, when hcount and vcount are both at their totals, wrap both to 0 in the same cycle.
REQ-017 SHALL, if a total changes so that the counter already exceeds it, count up to the maximum value (8'hFF or 10'h3FF) and then wrap to 0; the counter SHALL never lock up.
REQ-018 SHALL drive horizontal display enable high while hcount <= horiz_disp_en_cnt, and vertical display enable high while vcount <= vert_disp_en_end.
REQ-019 SHALL drive de_o as the AND of horizontal and vertical display enable.
REQ-020 SHALL set the hblank flag when hcount == horiz_blank_start, and clear it when hcount[5:0] == horiz_blank_end, evaluated after the set.
REQ-021 SHALL set the hretrace flag when hcount == horiz_retrace_start, and clear it when hcount[4:0] == horiz_retrace_end.
REQ-022 SHALL update the vblank flag (set at vert_blank_start, clear at vcount[7:0] == vert_blank_end) and the vretrace flag (set at vert_retrace_start, clear at vcount[3:0] == vert_retrace_end) only on hcount-wrap cycles, using the new vcount.
REQ-023 SHALL give clear priority when set and clear match in the same evaluation.
REQ-024 SHALL drive blank_o as hblank OR vblank.
REQ-025 SHALL drive hsync_o = HSYNC_POL while hretrace is set, else ~HSYNC_POL; vsync_o is formed the same way with VSYNC_POL.
REQ-026 SHALL register all outputs.
REQ-027 SHALL make hcount_o and vcount_o reflect the counters with 0 cycles of latency; de_o, blank_o, hsync_o and vsync_o SHALL correspond to the same registered counter values.
REQ-028 SHALL pulse line_start_o for one clock when hcount becomes 0, and frame_start_o when both counters become 0.
REQ-029 SHALL hold every output when char_en_i is low, except that the strobes are low.

Reset
REQ-030 SHALL, while reset_i is high, force counters to 0, all flags and shadows to 0, hsync_o = ~HSYNC_POL, vsync_o = ~VSYNC_POL, blank_o = 1, de_o = 0, and strobes to 0.
REQ-031 SHALL, when reset is asserted mid-line or mid-frame, abort immediately and restart from (0,0) on the first char_en_i after release, with shadows loaded on that cycle.

Verification
REQ-032 Basic line: htotal=9, hdisp=5, hblank 6/9, hretrace 7/8, char_en_i=1 -> de high for hcount 0..5, blank high for 6..8, hsync low for 7 only, hcount wraps 9->0.
REQ-033 Frame: vtotal=4, vdisp_end=2, vblank 3/4, vretrace 3/4 -> vsync low during line 3, blank for lines 3, frame_start_o once every 50 cycles.
REQ-034 Enable gating: char_en_i toggling every other cycle -> identical sequence at half rate, no strobes on idle cycles.
REQ-035 Shadowing: change htotal from 9 to 7 mid-frame -> period stays 10 until frame wrap, then 8.
REQ-036 Reset mid-frame at (4,2) -> outputs go to reset values asynchronously; after release the sequence restarts at (0,0).
REQ-037 Wrap-around: retrace end 5-bit match, hretrace_start=30, end=2 -> hsync asserted at 30..33 with htotal=40.
